// File: rtl/updown_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// updown_sweep_ctrl
//
// Purpose:
//   Sequencer for a free-running WIDTH-bit up/down counter. It drives the
//   counter's synchronous clear and direction inputs so the counter sweeps
//   back and forth between two bounds (lo, hi) for a commanded number of
//   passes. One pass is a full traverse lo->hi or hi->lo. Commands arrive on
//   a valid/ready handshake, one at a time.
//
// Ports:
//   clk         in   1      system clock, all state on rising edge
//   reset_n     in   1      asynchronous active-low reset
//   cmd_valid   in   1      sweep command present
//   cmd_ready   out  1      high only while idle; accept on valid & ready
//   cmd_lo      in   WIDTH  lower bound
//   cmd_hi      in   WIDTH  upper bound
//   cmd_passes  in   PW     number of passes to perform
//   abort       in   1      terminate the active sweep
//   cnt_y       in   WIDTH  counter output fed back
//   cnt_clr     out  1      counter sync clear (Mealy)
//   cnt_dir     out  1      counter direction, 1=up 0=down (Mealy)
//   busy        out  1      sequencer not idle
//   done        out  1      one-cycle pulse, sweep completed normally
//   err         out  1      one-cycle pulse, command rejected
//   pass_cnt    out  PW     passes completed in the current/last sweep
//
// The counter advances on every edge, so cnt_clr/cnt_dir must react in the
// same cycle the endpoint value is seen on cnt_y; they are combinational from
// state, latched bounds and cnt_y. All other outputs come straight from flops.
// The final endpoint cycle of a sweep (the "finish" cycle) is not a separate
// registered state: it is the UP/DOWN cycle in which the last pass completes,
// where cnt_clr is raised and the next state is IDLE.
// -----------------------------------------------------------------------------
module updown_sweep_ctrl #(
    parameter int WIDTH = 4,
    parameter int PW    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_lo,
    input  logic [WIDTH-1:0] cmd_hi,
    input  logic [PW-1:0]    cmd_passes,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_y,
    output logic             cnt_clr,
    output logic             cnt_dir,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [PW-1:0]    pass_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEEK = 2'd1,
        ST_UP   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [PW-1:0]    passes_q, passes_d;
    logic [PW-1:0]    pass_cnt_q, pass_cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic [PW-1:0]    pass_next_s;

    // A command is usable only with a non-empty range and at least one pass.
    function automatic logic cmd_is_legal(
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi,
        input logic [PW-1:0]    passes
    );
        cmd_is_legal = (lo < hi) && (passes != {PW{1'b0}});
    endfunction

    // Next-state, latched-command and Mealy counter-control logic.
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        passes_d    = passes_q;
        pass_cnt_d  = pass_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cnt_clr     = 1'b1;
        cnt_dir     = 1'b1;
        pass_next_s = pass_cnt_q + {{(PW-1){1'b0}}, 1'b1};

        case (state_q)
            ST_IDLE: begin
                // Counter held at 0 while idle; abort is meaningless here.
                cnt_clr = 1'b1;
                cnt_dir = 1'b1;
                if (cmd_valid) begin
                    lo_d       = cmd_lo;
                    hi_d       = cmd_hi;
                    passes_d   = cmd_passes;
                    pass_cnt_d = {PW{1'b0}};
                    if (cmd_is_legal(cmd_lo, cmd_hi, cmd_passes)) begin
                        state_d = ST_SEEK;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SEEK: begin
                if (abort) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    // Count up from 0; reaching lo is not a pass, just the start.
                    cnt_clr = 1'b0;
                    cnt_dir = 1'b1;
                    if (cnt_y == lo_q) begin
                        state_d = ST_UP;
                    end else begin
                        state_d = ST_SEEK;
                    end
                end
            end

            ST_UP: begin
                if (abort) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_clr = 1'b0;
                    if (cnt_y == hi_q) begin
                        // Turn at hi so the counter never wraps past the top.
                        cnt_dir    = 1'b0;
                        pass_cnt_d = pass_next_s;
                        if (pass_next_s == passes_q) begin
                            cnt_clr = 1'b1;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DOWN;
                        end
                    end else begin
                        cnt_dir = 1'b1;
                        state_d = ST_UP;
                    end
                end
            end

            ST_DOWN: begin
                if (abort) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_clr = 1'b0;
                    if (cnt_y == lo_q) begin
                        cnt_dir    = 1'b1;
                        pass_cnt_d = pass_next_s;
                        if (pass_next_s == passes_q) begin
                            cnt_clr = 1'b1;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_UP;
                        end
                    end else begin
                        cnt_dir = 1'b0;
                        state_d = ST_DOWN;
                    end
                end
            end

            default: begin
                // Unreachable encoding: fall back to the safe idle condition.
                cnt_clr = 1'b1;
                cnt_dir = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            lo_q       <= {WIDTH{1'b0}};
            hi_q       <= {WIDTH{1'b0}};
            passes_q   <= {PW{1'b0}};
            pass_cnt_q <= {PW{1'b0}};
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            passes_q   <= passes_d;
            pass_cnt_q <= pass_cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign pass_cnt  = pass_cnt_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
module tb_updown_sweep_ctrl;
    localparam int WIDTH = 4;
    localparam int PW    = 8;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic             cmd_valid  = 1'b0;
    logic [WIDTH-1:0] cmd_lo     = 4'd0;
    logic [WIDTH-1:0] cmd_hi     = 4'd0;
    logic [PW-1:0]    cmd_passes = 8'd0;
    logic             abort      = 1'b0;
    logic [WIDTH-1:0] cnt_y      = 4'd0;
    logic             cmd_ready, cnt_clr, cnt_dir, busy, done, err;
    logic [PW-1:0]    pass_cnt;

    int total = 0;
    int bad   = 0;

    // expected per-cycle counter value and pass count after a command is accepted
    int exp_y[$];
    int exp_pc[$];

    updown_sweep_ctrl #(.WIDTH(WIDTH), .PW(PW)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_passes(cmd_passes), .abort(abort),
        .cnt_y(cnt_y), .cnt_clr(cnt_clr), .cnt_dir(cnt_dir), .busy(busy),
        .done(done), .err(err), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    // the free-running up/down counter being sequenced (no reset, no enable)
    always @(posedge clk) begin
        cnt_y <= cnt_clr ? 4'd0 : (cnt_dir ? cnt_y + 4'd1 : cnt_y - 4'd1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference: seek 0..lo, then alternate lo+1..hi and hi-1..lo per pass
    task automatic build_exp(input int lo, input int hi, input int passes);
        exp_y.delete();
        exp_pc.delete();
        for (int v = 0; v <= lo; v++) begin
            exp_y.push_back(v);
            exp_pc.push_back(0);
        end
        for (int p = 1; p <= passes; p++) begin
            if (p % 2 == 1) begin
                for (int v = lo + 1; v <= hi; v++) begin
                    exp_y.push_back(v);
                    exp_pc.push_back(p - 1);
                end
            end else begin
                for (int v = hi - 1; v >= lo; v--) begin
                    exp_y.push_back(v);
                    exp_pc.push_back(p - 1);
                end
            end
        end
    endtask

    task automatic issue(input int lo, input int hi, input int passes);
        cmd_lo     = 4'(lo);
        cmd_hi     = 4'(hi);
        cmd_passes = 8'(passes);
        cmd_valid  = 1'b1;
    endtask

    // expects a command already presented while idle; checks the whole sweep
    task automatic run_sweep(input int lo, input int hi, input int passes, input int abort_at);
        bit legal;
        legal = (lo < hi) && (passes != 0);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_before_accept: got %b want 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        if (!legal) begin
            total++;
            if (err !== 1'b1 || busy !== 1'b0 || cnt_clr !== 1'b1 || pass_cnt !== 8'd0 || done !== 1'b0) begin
                bad++;
                $display("FAIL reject lo=%0d hi=%0d p=%0d: err=%b busy=%b clr=%b pc=%0d done=%b want 1 0 1 0 0",
                         lo, hi, passes, err, busy, cnt_clr, pass_cnt, done);
            end
            step();
            total++;
            if (err !== 1'b0 || busy !== 1'b0 || cnt_clr !== 1'b1) begin
                bad++;
                $display("FAIL reject_after: err=%b busy=%b clr=%b want 0 0 1", err, busy, cnt_clr);
            end
            return;
        end
        build_exp(lo, hi, passes);
        for (int i = 0; i < exp_y.size(); i++) begin
            total++;
            if (cnt_y !== 4'(exp_y[i])) begin
                bad++;
                $display("FAIL cnt_y lo=%0d hi=%0d p=%0d idx=%0d: got %0d want %0d", lo, hi, passes, i, cnt_y, exp_y[i]);
            end
            total++;
            if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL status idx=%0d: busy=%b done=%b err=%b ready=%b want 1 0 0 0", i, busy, done, err, cmd_ready);
            end
            total++;
            if (pass_cnt !== 8'(exp_pc[i])) begin
                bad++;
                $display("FAIL pass_cnt idx=%0d: got %0d want %0d", i, pass_cnt, exp_pc[i]);
            end
            if (i == abort_at) begin
                abort = 1'b1;
                #1;
                total++;
                if (cnt_clr !== 1'b1) begin
                    bad++;
                    $display("FAIL abort_clr idx=%0d: got %b want 1", i, cnt_clr);
                end
                step();
                abort = 1'b0;
                total++;
                if (cnt_y !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || pass_cnt !== 8'(exp_pc[i])) begin
                    bad++;
                    $display("FAIL after_abort idx=%0d: y=%0d busy=%b done=%b pc=%0d want 0 0 0 %0d",
                             i, cnt_y, busy, done, pass_cnt, exp_pc[i]);
                end
                return;
            end
            step();
        end
        total++;
        if (cnt_y !== 4'd0 || done !== 1'b1 || busy !== 1'b0 || pass_cnt !== 8'(passes) || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL finish lo=%0d hi=%0d p=%0d: y=%0d done=%b busy=%b pc=%0d ready=%b want 0 1 0 %0d 1",
                     lo, hi, passes, cnt_y, done, busy, pass_cnt, cmd_ready, passes);
        end
        step();
        total++;
        if (done !== 1'b0 || cnt_y !== 4'd0) begin
            bad++;
            $display("FAIL done_pulse: done=%b y=%0d want 0 0", done, cnt_y);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || pass_cnt !== 8'd0 ||
            cnt_clr !== 1'b1 || cnt_dir !== 1'b1 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b err=%b pc=%0d clr=%b dir=%b ready=%b",
                     busy, done, err, pass_cnt, cnt_clr, cnt_dir, cmd_ready);
        end
        reset_n = 1'b1;
        step();
        total++;
        if (cnt_y !== 4'd0 || busy !== 1'b0 || cnt_clr !== 1'b1) begin
            bad++;
            $display("FAIL post_reset: y=%0d busy=%b clr=%b want 0 0 1", cnt_y, busy, cnt_clr);
        end
    endtask

    task automatic test_basic();
        issue(2, 4, 2);  run_sweep(2, 4, 2, -1);
        issue(0, 3, 3);  run_sweep(0, 3, 3, -1);
        issue(0, 15, 1); run_sweep(0, 15, 1, -1);
        issue(14, 15, 4); run_sweep(14, 15, 4, -1);
    endtask

    task automatic test_invalid();
        issue(5, 5, 2);  run_sweep(5, 5, 2, -1);
        issue(9, 4, 1);  run_sweep(9, 4, 1, -1);
        issue(2, 6, 0);  run_sweep(2, 6, 0, -1);
    endtask

    task automatic test_abort();
        issue(1, 6, 2);  run_sweep(1, 6, 2, 3);
        // abort coinciding with the final endpoint: no done, no increment
        build_exp(2, 4, 2);
        issue(2, 4, 2);  run_sweep(2, 4, 2, exp_y.size() - 1);
        // abort while idle is ignored
        abort = 1'b1;
        step();
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || cnt_clr !== 1'b1 || cnt_y !== 4'd0) begin
            bad++;
            $display("FAIL abort_idle: busy=%b done=%b clr=%b y=%0d", busy, done, cnt_clr, cnt_y);
        end
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        issue(1, 5, 2);
        step();
        // next command held by the source while the sequencer is busy
        issue(2, 3, 1);
        build_exp(1, 5, 2);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1 || cnt_y !== 4'(exp_y[i])) begin
                bad++;
                $display("FAIL held_cmd idx=%0d: ready=%b busy=%b y=%0d want 0 1 %0d", i, cmd_ready, busy, cnt_y, exp_y[i]);
            end
            step();
        end
        total++;
        if (cnt_y !== 4'd4) begin
            bad++;
            $display("FAIL mid_down: y=%0d want 4", cnt_y);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || cnt_clr !== 1'b1 || cmd_ready !== 1'b1 || pass_cnt !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: busy=%b clr=%b ready=%b pc=%0d want 0 1 1 0", busy, cnt_clr, cmd_ready, pass_cnt);
        end
        step();
        total++;
        if (cnt_y !== 4'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_clear: y=%0d busy=%b want 0 0", cnt_y, busy);
        end
        reset_n = 1'b1;
        run_sweep(2, 3, 1, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int lo, hi, p, ab;
            lo = $urandom_range(0, 15);
            hi = $urandom_range(0, 15);
            p  = $urandom_range(0, 4);
            ab = -1;
            if ((lo < hi) && (p != 0) && ($urandom_range(0, 2) == 0)) begin
                build_exp(lo, hi, p);
                ab = $urandom_range(0, exp_y.size() - 1);
            end
            issue(lo, hi, p);
            run_sweep(lo, hi, p, ab);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
